// File: rtl/mem_dump_reader_if.sv
// rtl/mem_dump_reader_if.sv - data memory read port and host word stream of the dump reader
// master: the reader; slave: data memory plus host consumer.
interface mem_dump_reader_if #(
   parameter int ARQ    = 16,
   parameter int MEM_AW = 10
);
   logic              mem_rd_en;
   logic [MEM_AW-1:0] mem_addr;
   logic [ARQ-1:0]    mem_rd_data;
   logic [ARQ-1:0]    out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;

   modport master (
      output mem_rd_en, mem_addr, out_data, out_valid, out_last,
      input  mem_rd_data, out_ready
   );

   modport slave (
      input  mem_rd_en, mem_addr, out_data, out_valid, out_last,
      output mem_rd_data, out_ready
   );
endinterface

// File: rtl/mem_dump_reader.sv
// rtl/mem_dump_reader.sv - halts the core, drains stores, streams a data memory window to the host
// Reads are issued only when the 2-entry FIFO is guaranteed room for the returning word.
module mem_dump_reader #(
   parameter int ARQ          = 16,
   parameter int MEM_AW       = 10,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [MEM_AW-1:0] base_addr,
   input  logic [MEM_AW:0]   word_count,
   output logic              halt_cpu,
   output logic              busy,
   output logic              done,
   mem_dump_reader_if.master bus
);
   localparam int DW = $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DRAIN, READ, FINISH} state_t;

   state_t            state, state_next;
   logic [DW-1:0]     drain_cnt;
   logic [MEM_AW-1:0] addr;
   logic [MEM_AW:0]   issue_left;
   logic [MEM_AW:0]   pop_left;
   logic              rd_pending;
   logic [ARQ-1:0]    fifo_mem [2];
   logic              wr_ptr, rd_ptr;
   logic [1:0]        fifo_count;
   logic [2:0]        occupancy;
   logic              issue, pop, accept;

   assign pop       = bus.out_valid & bus.out_ready;
   assign occupancy = {1'b0, fifo_count} + {2'b00, rd_pending} - {2'b00, pop};
   assign accept    = (state == IDLE) && start && (word_count != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      issue      = 1'b0;
      case (state)
         IDLE:   if (start) state_next = (word_count == '0) ? FINISH : DRAIN;
         DRAIN:  if (drain_cnt == '0) state_next = READ;
         READ: begin
            issue = (issue_left != '0) && (occupancy < 3'd2);
            if (pop && pop_left == (MEM_AW+1)'(1)) state_next = FINISH;
         end
         FINISH: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign halt_cpu      = (state == DRAIN) || (state == READ);
   assign busy          = (state != IDLE);
   assign done          = (state == FINISH);
   assign bus.mem_rd_en = issue;
   assign bus.mem_addr  = addr;
   assign bus.out_valid = (fifo_count != 2'd0);
   assign bus.out_data  = fifo_mem[rd_ptr];
   assign bus.out_last  = bus.out_valid && (pop_left == (MEM_AW+1)'(1));

   // rd_pending clears on reset so a read return landing after reset is never captured.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drain_cnt   <= '0;
         addr        <= '0;
         issue_left  <= '0;
         pop_left    <= '0;
         rd_pending  <= 1'b0;
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         fifo_count  <= 2'd0;
      end else begin
         rd_pending <= issue;
         if (accept) begin
            addr       <= base_addr;
            issue_left <= word_count;
            pop_left   <= word_count;
            drain_cnt  <= DW'(DRAIN_CYCLES - 1);
         end
         if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
         if (issue) begin
            addr       <= addr + 1'b1;
            issue_left <= issue_left - 1'b1;
         end
         if (pop) begin
            rd_ptr   <= ~rd_ptr;
            pop_left <= pop_left - 1'b1;
         end
         if (rd_pending) begin
            fifo_mem[wr_ptr] <= bus.mem_rd_data;
            wr_ptr           <= ~wr_ptr;
         end
         fifo_count <= fifo_count + {1'b0, rd_pending} - {1'b0, pop};
      end
   end
endmodule

// File: tb/tb_mem_dump_reader.sv
// tb/tb_mem_dump_reader.sv - randomized bench for mem_dump_reader against a queue-based dump model
// Expected reads and words come from the window arithmetic on a bench-owned memory image.
module tb_mem_dump_reader;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [9:0]  base_addr = '0;
   logic [10:0] word_count = '0;
   logic        halt_cpu, busy, done;

   mem_dump_reader_if #(.ARQ(16), .MEM_AW(10)) bus ();

   mem_dump_reader #(.ARQ(16), .MEM_AW(10), .DRAIN_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
      .halt_cpu(halt_cpu), .busy(busy), .done(done), .bus(bus.master)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [1024];
   logic [15:0] rd_q = '0;
   always @(posedge clk) if (bus.mem_rd_en) rd_q <= mem[bus.mem_addr];
   assign bus.mem_rd_data = rd_q;

   int errors = 0;
   int checks = 0;
   int ready_mode = 0;
   int ready_phase = 0;
   logic [9:0]  exp_addr [$];
   logic [15:0] exp_data [$];
   logic [9:0]  rd_log [$];
   bit   expect_done = 0;
   int   words_seen = 0;
   int   lasts_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0: bus.out_ready = 1'b1;
            1: begin bus.out_ready = (ready_phase % 3 == 0); ready_phase++; end
            default: bus.out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Compare process: reads, words, stall stability, outstanding bound and done.
   initial begin
      int issued, accepted;
      bit prev_stall;
      logic [15:0] prev_data;
      issued = 0; accepted = 0; prev_stall = 0; prev_data = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            issued = 0; accepted = 0; prev_stall = 0;
         end else begin
            if (prev_stall) begin
               chk("stall_valid_held", bus.out_valid, 1);
               chk("stall_data_held", bus.out_data, prev_data);
            end
            if (bus.mem_rd_en) begin
               issued++;
               rd_log.push_back(bus.mem_addr);
               chk("halt_during_read", halt_cpu, 1);
               if (exp_addr.size() == 0) chk("unexpected_read", 1, 0);
               else chk("read_addr", bus.mem_addr, exp_addr.pop_front());
            end
            if (bus.out_valid && bus.out_ready) begin
               accepted++;
               words_seen++;
               if (bus.out_last) lasts_seen++;
               if (exp_data.size() == 0) chk("unexpected_word", 1, 0);
               else begin
                  chk("out_last", bus.out_last, exp_data.size() == 1);
                  chk("out_data", bus.out_data, exp_data.pop_front());
               end
            end
            chk("outstanding_le_2", (issued - accepted) <= 2, 1);
            if (done) begin
               if (!expect_done) chk("spurious_done", 1, 0);
               else begin
                  chk("done_words_left", exp_data.size(), 0);
                  chk("done_halt_low", halt_cpu, 0);
                  chk("done_busy_high", busy, 1);
               end
               expect_done = 0;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
         end
      end
   end

   task automatic start_dump(input logic [9:0] b, input logic [10:0] n);
      for (int i = 0; i < int'(n); i++) begin
         logic [9:0] a;
         a = 10'((int'(b) + i) % 1024);
         exp_addr.push_back(a);
         exp_data.push_back(mem[a]);
      end
      expect_done = 1;
      rd_log.delete();
      words_seen = 0;
      lasts_seen = 0;
      @(posedge clk); #1;
      start = 1'b1; base_addr = b; word_count = n;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      bit seen;
      seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      chk({name, "_done_timeout"}, seen, 1);
      @(negedge clk);
      chk({name, "_idle_after_done"}, busy, 0);
   endtask

   task automatic check_reset_values(input string name);
      chk({name, "_halt"}, halt_cpu, 0);
      chk({name, "_busy"}, busy, 0);
      chk({name, "_done"}, done, 0);
      chk({name, "_rd_en"}, bus.mem_rd_en, 0);
      chk({name, "_addr"}, bus.mem_addr, 0);
      chk({name, "_valid"}, bus.out_valid, 0);
      chk({name, "_last"}, bus.out_last, 0);
      chk({name, "_data"}, bus.out_data, 0);
   endtask

   initial begin
      bit got;
      for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
      for (int i = 0; i < 4; i++) mem[16 + i] = 16'hA000 + 16'(i);

      #2; check_reset_values("reset");
      @(posedge clk); @(posedge clk); #1 rst = 1'b0;

      // Basic dump with hand-computed cycle timing.
      ready_mode = 0;
      start_dump(10'h010, 11'd4);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         chk($sformatf("basic_halt_c%0d", k), halt_cpu, (k <= 10));
         chk($sformatf("basic_busy_c%0d", k), busy, (k <= 11));
         chk($sformatf("basic_rd_en_c%0d", k), bus.mem_rd_en, (k >= 5 && k <= 8));
         chk($sformatf("basic_valid_c%0d", k), bus.out_valid, (k >= 7 && k <= 10));
         chk($sformatf("basic_last_c%0d", k), bus.out_last, (k == 10));
         chk($sformatf("basic_done_c%0d", k), done, (k == 11));
         if (k >= 7 && k <= 10) chk($sformatf("basic_data_c%0d", k), bus.out_data, 32'hA000 + k - 7);
      end

      // Back-pressure 1,0,0 pattern on the same window.
      ready_mode = 1; ready_phase = 0;
      start_dump(10'h010, 11'd4);
      wait_done("backpressure", 200);
      chk("backpressure_words", words_seen, 4);

      // Wrap-around.
      ready_mode = 0;
      start_dump(10'd1022, 11'd4);
      wait_done("wrap", 100);
      chk("wrap_reads", rd_log.size(), 4);
      if (rd_log.size() == 4) begin
         chk("wrap_a0", rd_log[0], 1022);
         chk("wrap_a1", rd_log[1], 1023);
         chk("wrap_a2", rd_log[2], 0);
         chk("wrap_a3", rd_log[3], 1);
      end

      // Zero length.
      start_dump(10'd5, 11'd0);
      @(negedge clk);
      chk("zero_done_c1", done, 1);
      chk("zero_busy_c1", busy, 1);
      chk("zero_halt_c1", halt_cpu, 0);
      @(negedge clk);
      chk("zero_busy_c2", busy, 0);
      chk("zero_reads", rd_log.size(), 0);

      // Randomized windows with random back-pressure.
      ready_mode = 2;
      for (int t = 0; t < 5; t++) begin
         start_dump(10'($urandom_range(0, 1023)), 11'($urandom_range(1, 40)));
         wait_done($sformatf("rand%0d", t), 400);
      end

      // Full length.
      start_dump(10'd0, 11'd1024);
      wait_done("full", 6000);
      chk("full_words", words_seen, 1024);
      chk("full_lasts", lasts_seen, 1);
      chk("full_last_read", (rd_log.size() > 0) ? rd_log[rd_log.size()-1] : 10'd0, 1023);

      // Reset mid-dump.
      ready_mode = 0;
      start_dump(10'd200, 11'd8);
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (words_seen >= 2) got = 1;
      end
      chk("midreset_two_words", got, 1);
      @(posedge clk); #3;
      rst = 1'b1;
      exp_addr.delete(); exp_data.delete(); expect_done = 0;
      #1 check_reset_values("midreset");
      @(posedge clk); @(posedge clk); #1 rst = 1'b0;
      start_dump(10'd300, 11'd8);
      wait_done("after_reset", 100);
      chk("after_reset_words", words_seen, 8);

      // Start while busy is ignored.
      start_dump(10'd100, 11'd6);
      got = 0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (bus.mem_rd_en) got = 1;
      end
      chk("busy_first_read", got, 1);
      @(posedge clk); #1;
      start = 1'b1; base_addr = 10'd500; word_count = 11'd3;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("start_busy", 100);
      chk("start_busy_reads", rd_log.size(), 6);
      chk("start_busy_words", words_seen, 6);

      repeat (3) @(negedge clk);
      chk("final_idle", busy, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
